// File: rtl/sigdata_gen.sv
// sigdata_gen: request-driven data word generator (inc/dec/LFSR/hold) with fixed latency
module sigdata_gen #(
  parameter int DW = 4,
  parameter int LAT = 2,
  parameter int STEP = 1,
  parameter logic [DW-1:0] TAPS = 4'b1100,
  parameter int CW = 16
) (
  input  logic          sclk,
  input  logic          rst,
  input  logic          ask_for_data,
  input  logic [1:0]    mode,
  input  logic          load,
  input  logic [DW-1:0] seed,
  output logic [DW-1:0] data,
  output logic          data_vld,
  output logic          busy,
  output logic          overrun,
  output logic [CW-1:0] req_cnt
);
  localparam int WW = $clog2(LAT + 1);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d, lfsr, next_val;
  logic [CW-1:0] req_cnt_q, req_cnt_d;
  logic ask_q, vld_q, vld_d, ovr_q, ovr_d, req_edge;
  assign req_edge = ask_for_data & ~ask_q;
  assign lfsr = (data_q == '0) ? DW'(1) : {data_q[DW-2:0], ^(data_q & TAPS)};
  assign next_val = (mode == 2'b00) ? data_q + DW'(STEP) :
                    (mode == 2'b01) ? data_q - DW'(STEP) :
                    (mode == 2'b10) ? lfsr : data_q;
  // Next-state: load aborts everything; IDLE accepts an edge; WAIT counts down, then serves
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    data_d = data_q;
    vld_d = 1'b0;
    ovr_d = ovr_q;
    req_cnt_d = req_cnt_q;
    if (load) begin
      data_d = seed;
      ovr_d = 1'b0;
      state_d = IDLE;
      cnt_d = '0;
    end else if (state_q == IDLE) begin
      if (req_edge) begin
        state_d = WAIT;
        cnt_d = WW'(LAT - 1);
      end
    end else begin
      if (req_edge) ovr_d = 1'b1;
      if (cnt_q != '0) cnt_d = cnt_q - WW'(1);
      else begin
        data_d = next_val;
        vld_d = 1'b1;
        req_cnt_d = (&req_cnt_q) ? req_cnt_q : req_cnt_q + CW'(1);
        state_d = IDLE;
      end
    end
  end
  // State registers; the edge-detect flop keeps sampling through reset
  always_ff @(posedge sclk) begin
    ask_q <= ask_for_data;
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      data_q <= '0;
      vld_q <= 1'b0;
      ovr_q <= 1'b0;
      req_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      vld_q <= vld_d;
      ovr_q <= ovr_d;
      req_cnt_q <= req_cnt_d;
    end
  end
  assign data = data_q;
  assign data_vld = vld_q;
  assign busy = (state_q == WAIT);
  assign overrun = ovr_q;
  assign req_cnt = req_cnt_q;
endmodule
